// File: rtl/uart_inst_loader.sv
// UART program loader: receives A5 / len16 / little-endian words and writes them into
// instruction RAM from address 0, holding the CPU in reset until the image is complete.
module uart_inst_loader #(
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned BAUD        = 115200,
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DEPTH       = 4096,
    parameter int unsigned TIMEOUT_CYC = 5000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int unsigned DIV   = CLK_HZ / BAUD;
    localparam int unsigned CNT_W = $clog2(DIV + 1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIV / 2 - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic [2:0] {StIdle, StLen0, StLen1, StData, StDone, StErr} state_e;

    rx_state_e        rx_state_q, rx_state_d;
    logic             rx_s1_q, rx_s2_q, rx_s3_q;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             byte_stb, frame_err;

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [23:0]       word_q, word_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0]   words_q, words_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic              busy_st;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        byte_stb   = 1'b0;
        frame_err  = 1'b0;
        case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = '0;
                if (rx_s3_q && !rx_s2_q) rx_state_d = RxStart;
            end
            RxStart: if (rx_cnt_q == HALF_LAST) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                // Line back high at mid start bit: treat as a glitch.
                rx_state_d = rx_s2_q ? RxIdle : RxData;
            end
            RxData: if (rx_cnt_q == DIV_LAST) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 1'b1;
                if (rx_bit_q == 3'd7) rx_state_d = RxStop;
            end
            RxStop: if (rx_cnt_q == DIV_LAST) begin
                rx_cnt_d   = '0;
                rx_state_d = RxIdle;
                byte_stb   = rx_s2_q;
                frame_err  = !rx_s2_q;
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    assign busy_st = (state_q == StLen0) || (state_q == StLen1) || (state_q == StData);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        words_d    = words_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
        case (state_q)
            StIdle, StDone, StErr: if (byte_stb && rx_shift_q == 8'hA5) begin
                state_d = StLen0;
                words_d = '0;
                addr_d  = '0;
            end
            StLen0: if (byte_stb) begin
                len_d[7:0] = rx_shift_q;
                state_d    = StLen1;
            end
            StLen1: if (byte_stb) begin
                len_d[15:8] = rx_shift_q;
                byte_cnt_d  = '0;
                if ({rx_shift_q, len_q[7:0]} == 16'd0)          state_d = StDone;
                else if ({rx_shift_q, len_q[7:0]} > 16'(DEPTH)) state_d = StErr;
                else                                            state_d = StData;
            end
            StData: begin
                if (byte_stb) begin
                    byte_cnt_d = byte_cnt_q + 1'b1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {rx_shift_q, word_q};
                        addr_d  = words_q[ADDR_W-1:0];
                        words_d = words_q + 1'b1;
                    end else begin
                        word_d = {rx_shift_q, word_q[23:8]};
                    end
                end
                // Finish one cycle after the last write so it lands before CPU release.
                if (we_q && 32'(words_q) == 32'(len_q)) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase
        if (busy_st && (frame_err || tmr_q == TMR_LAST)) state_d = StErr;
        tmr_d = (byte_stb || !busy_st || state_d != state_q) ? '0 : tmr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            state_q    <= StIdle;
            len_q      <= '0;
            word_q     <= '0;
            byte_cnt_q <= '0;
            words_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            tmr_q      <= '0;
        end else begin
            rx_s1_q    <= uart_rx;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            state_q    <= state_d;
            len_q      <= len_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            words_q    <= words_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            tmr_q      <= tmr_d;
        end
    end

    assign ram_we       = we_q;
    assign ram_addr     = addr_q;
    assign ram_wdata    = wdata_q;
    assign words_loaded = words_q;
    assign busy         = busy_st;
    assign done         = (state_q == StDone);
    assign err          = (state_q == StErr);
    assign cpu_hold     = (state_q != StDone);
endmodule

// File: tb/tb_uart_inst_loader.sv
// Bench for uart_inst_loader: serial stimulus against a packet-level model of expected writes
// and final status; a per-cycle monitor checks every RAM write and the output flag rules.
module tb_uart_inst_loader;
    localparam int unsigned CLK_HZ      = 800;
    localparam int unsigned BAUD        = 100;
    localparam int unsigned ADDR_W      = 3;
    localparam int unsigned DEPTH       = 8;
    localparam int unsigned TIMEOUT_CYC = 300;
    localparam int unsigned DIV         = CLK_HZ / BAUD;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              uart_rx = 1'b1;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic              cpu_hold, busy, done, err;
    logic [ADDR_W:0]   words_loaded;

    typedef struct {
        int          addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [31:0] obs_data[$];
    int          obs_addr[$];
    bit          m_done, m_err, m_timeout;
    int          m_words;
    int          checks = 0;
    int          errors = 0;
    bit          done_prev = 1'b0;

    uart_inst_loader #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Per-cycle monitor: every write must match the next expected write, in order.
    always @(negedge clk) begin
        wr_t w;
        if (!rst) begin
            check("hold_vs_done", cpu_hold, !done);
            check("flags_exclusive", (int'(done) + int'(err) + int'(busy)) <= 1, 1);
            if (ram_we) begin
                check("we_while_busy", busy, 1);
                check("we_expected", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0) begin
                    w = exp_wr.pop_front();
                    check("we_addr", ram_addr, w.addr);
                    check("we_data", ram_wdata, w.data);
                end
                obs_addr.push_back(int'(ram_addr));
                obs_data.push_back(ram_wdata);
            end
            if (done && !done_prev) check("writes_before_done", exp_wr.size(), 0);
            done_prev = done;
        end else begin
            done_prev = 1'b0;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic tx_bit(input logic b);
        uart_rx = b;
        repeat (DIV) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
        tx_bit(1'b0);
        for (int i = 0; i < 8; i++) tx_bit(b[i]);
        tx_bit(stop_ok);
        uart_rx = 1'b1;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    // Packet-level model: header, length, then whole words; anything short of len times out.
    task automatic model_load(input logic [7:0] p[$]);
        int len, n;
        wr_t w;
        len       = int'({p[2], p[1]});
        m_words   = 0;
        m_done    = 1'b0;
        m_err     = 1'b0;
        m_timeout = 1'b0;
        if (len == 0) begin
            m_done = 1'b1;
        end else if (len > DEPTH) begin
            m_err = 1'b1;
        end else begin
            n = (p.size() - 3) / 4;
            if (n > len) n = len;
            for (int i = 0; i < n; i++) begin
                w.addr = i;
                w.data = {p[3+4*i+3], p[3+4*i+2], p[3+4*i+1], p[3+4*i]};
                exp_wr.push_back(w);
            end
            m_words = n;
            if (n == len) m_done = 1'b1;
            else begin
                m_err     = 1'b1;
                m_timeout = 1'b1;
            end
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, ".done"}, done, m_done);
        check({tag, ".err"}, err, m_err);
        check({tag, ".cpu_hold"}, cpu_hold, !m_done);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".words_loaded"}, words_loaded, m_words);
        check({tag, ".pending_writes"}, exp_wr.size(), 0);
    endtask

    task automatic run_load(input logic [7:0] p[$], input string tag);
        model_load(p);
        foreach (p[i]) send_byte(p[i], 1'b1, int'($urandom_range(0, 3 * DIV)));
        if (m_timeout) repeat (TIMEOUT_CYC + 4 * DIV) @(posedge clk);
        else repeat (2 * DIV) @(posedge clk);
        #1;
        check_status(tag);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".ram_we"}, ram_we, 0);
        check({tag, ".ram_addr"}, ram_addr, 0);
        check({tag, ".ram_wdata"}, ram_wdata, 0);
        check({tag, ".cpu_hold"}, cpu_hold, 1);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".err"}, err, 0);
        check({tag, ".words_loaded"}, words_loaded, 0);
    endtask

    initial begin
        logic [7:0] p[$];
        int         len, keep;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // One-cycle low glitch must be rejected, else the header that follows is misframed.
        uart_rx = 1'b0;
        @(posedge clk);
        #1;
        uart_rx = 1'b1;
        repeat (DIV) @(posedge clk);
        #1;
        check("glitch.busy", busy, 0);
        check("glitch.err", err, 0);

        obs_data.delete();
        obs_addr.delete();
        p = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'hB7, 8'h02, 8'h00, 8'h00};
        run_load(p, "two_words");
        check("two_words.count", obs_data.size(), 2);
        if (obs_data.size() == 2) begin
            check("two_words.addr0", obs_addr[0], 0);
            check("two_words.data0", obs_data[0], 32'h00A00513);
            check("two_words.addr1", obs_addr[1], 1);
            check("two_words.data1", obs_data[1], 32'h000002B7);
        end
        check("two_words.lit_words", words_loaded, 2);
        check("two_words.lit_hold", cpu_hold, 0);

        p = {8'hA5, 8'h00, 8'h00};
        run_load(p, "len_zero");
        check("len_zero.lit_done", done, 1);

        p = {8'hA5, 8'h01, 8'h10};
        run_load(p, "len_big");
        check("len_big.lit_err", err, 1);

        p = {8'hA5, 8'h01, 8'h00, 8'h13, 8'h05};
        run_load(p, "timeout");
        check("timeout.lit_err", err, 1);
        p = {8'hA5, 8'h01, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
        run_load(p, "after_timeout");

        p = {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        model_load(p);
        foreach (p[i]) send_byte(p[i], 1'b1, int'($urandom_range(0, DIV)));
        send_byte(8'h66, 1'b0, 2 * DIV);
        repeat (2 * DIV) @(posedge clk);
        #1;
        check_status("framing");

        p = {8'hA5, 8'(DEPTH), 8'h00};
        for (int i = 0; i < 4 * DEPTH; i++) p.push_back(8'($urandom));
        run_load(p, "full_depth");
        check("full_depth.last_addr", ram_addr, DEPTH - 1);

        for (int k = 0; k < 5; k++) begin
            len = int'($urandom_range(0, DEPTH + 2));
            p   = {8'hA5, len[7:0], len[15:8]};
            if (len >= 1 && len <= DEPTH) begin
                for (int i = 0; i < 4 * len; i++) p.push_back(8'($urandom));
                if ($urandom_range(0, 3) == 0) begin
                    keep = int'($urandom_range(0, 4 * len - 1));
                    while (p.size() > 3 + keep) void'(p.pop_back());
                end
            end
            run_load(p, "random");
        end

        p = {8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_load(p, "pre_restart");
        send_byte(8'hA5, 1'b1, 0);
        check("restart.cpu_hold", cpu_hold, 1);
        check("restart.done", done, 0);
        check("restart.busy", busy, 1);
        send_byte(8'h01, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'h12, 1'b1, 0);
        send_byte(8'h34, 1'b1, 0);
        tx_bit(1'b0);
        tx_bit(1'b1);
        #3;
        rst = 1'b1;
        #2;
        check_reset_values("async_reset");
        uart_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("async_reset.pending_writes", exp_wr.size(), 0);
        exp_wr.delete();

        p = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        run_load(p, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
